rr_mux_4t1_32: RTL and testbench
================================

Name: rr_mux_4t1_32

Overview:
- Merges four 32-bit valid/ready source channels onto one registered 32-bit output channel.
- Uses a round-robin arbiter to pick the source each cycle.
- This is the collecting counterpart of the team's 1-to-4 32-bit demux: the demux fans one stream out to four consumers, and this block funnels four producers back into one consumer.
- It sits in front of shared single-port resources, such as a writeback bus or a memory request port.

Parameters:
- W, 32, data width of every channel.
- PTR_RST, 0, 2-bit index of the highest-priority channel after reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  4  per-channel valid; bit i belongs to channel i.
- in_data_arr  input  W x 4  per-channel data, unpacked array [3:0]; element i belongs to channel i.
- in_ready  output  4  per-channel ready; at most one bit is high in any cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered data word.
- out_sel  output  2  index of the channel the current out_data came from.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=PTR_RST.
  - Reset takes priority over any transfer in the same cycle.
  - A held word is discarded; no in_ready handshake completes on that edge.
- Load enable: load_en = !out_valid | out_ready. The output register takes a new word when it is empty or being drained in the same cycle, so throughput is one word per clock.
- Grant (combinational):
  - Search the channels in order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first with in_valid high wins.
  - in_ready[g] = load_en for the winning channel g; all other in_ready bits are 0.
  - With no requester, in_ready = 0.
  - in_ready must not depend on in_valid of the same channel in any way other than through this grant selection.
- Transfer: channel g completes a transfer when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= in_data_arr[g], out_sel <= g, out_valid <= 1.
  - ptr <= g+1 mod 4, so the just-served channel becomes lowest priority.
- Drain only (out_valid & out_ready, no transfer): out_valid <= 0; out_data and out_sel hold their values.
- Stall (out_valid & !out_ready): out_valid, out_data, out_sel and ptr all hold; in_ready = 0.
- Latency: 1 cycle from input handshake to out_valid.
- Simultaneous drain and load: the new word replaces the old one with no bubble.
- ptr changes only on a completed transfer. Idle cycles and stalls never move it.
- Fairness: with all four channels continuously valid and out_ready=1, grants cycle PTR_RST, PTR_RST+1, ... with no channel skipped. Under continuous contention, each channel waits at most 3 transfers.
- Input data is not registered, so upstream must hold in_data_arr[i] stable while in_valid[i] is high and unacknowledged.
- No combinational path from out_ready to out_valid or out_data. The only combinational path is out_ready -> in_ready.

Optional Feature:
- Macro: RR_MUX_FIXED_PRIO_EN.
- Defined:
  - Round-robin is replaced by fixed priority: channel 0 highest, channel 3 lowest.
  - ptr is removed and PTR_RST is ignored.
  - All other handshake, latency and reset rules are unchanged.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset mid-stall: hold out_valid=1, out_ready=0 with out_data=0xDEADBEEF, then pulse rst one cycle -> next cycle out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Single source: only in_valid[2]=1 with 0x00000022, out_ready=1 -> in_ready=0100. The cycle after, out_valid=1, out_data=0x00000022, out_sel=2, and ptr moves to 3.
- Full contention: all in_valid=1 (data 0xA0..0xA3), out_ready=1, PTR_RST=0 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1 from cycle 1 (no bubbles).
- Backpressure: contention as above, out_ready=0 for 3 cycles after the first word -> out_data stays 0xA0, out_sel stays 0, in_ready=0000 throughout. On release the next word is 0xA1.
- Skip idle channels: in_valid=1001, ptr=1 -> grants 3 then 0 then 3. Channels 1 and 2 never get in_ready.
- RR_MUX_FIXED_PRIO_EN defined: all in_valid=1, out_ready=1 -> out_sel stays 0 every cycle. Drop in_valid[0] -> out_sel becomes 1.

Source files
------------

// File: rtl/rr_mux_4t1_32.sv
// Four-to-one 32-bit valid/ready merge with a registered output and a round-robin arbiter.
// Define RR_MUX_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.
module rr_mux_4t1_32 #(
    parameter int unsigned W       = 32,
    parameter logic [1:0]  PTR_RST = 2'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data_arr [3:0],
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_ready
);

    logic       load_en;
    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic [1:0] base;
    logic       xfer;

    assign load_en = !out_valid || out_ready;
    assign xfer    = gnt_found && load_en;

`ifdef RR_MUX_FIXED_PRIO_EN
    assign base = 2'd0;
`else
    logic [1:0] ptr;

    // The just-served channel drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PTR_RST;
        end else if (xfer) begin
            ptr <= gnt_idx + 2'd1;
        end
    end

    assign base = ptr;
`endif

    // First requester found when scanning upward from base, wrapping mod 4.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = base + 2'(k);
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        in_ready = 4'b0000;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data_arr[gnt_idx];
            out_sel   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_4t1_32.sv
// Directed self-checking bench for rr_mux_4t1_32.
// Round-robin scenarios run by default; fixed-priority ones when RR_MUX_FIXED_PRIO_EN is set.
module tb_rr_mux_4t1_32;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data [3:0];
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int n_chk;
    int n_fail;

    rr_mux_4t1_32 #(.W(32), .PTR_RST(2'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data_arr(in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_contention_data();
        for (int i = 0; i < 4; i++) in_data[i] = 32'hA0 + 32'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0
            || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h sel=%0d rdy=%b want 0 0 0 0000",
                     out_valid, out_data, out_sel, in_ready);
        end
    endtask

    task automatic test_reset_mid_stall();
        in_data[0] = 32'hDEADBEEF;
        in_valid = 4'b0001;
        out_ready = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_load_rdy: got %b want 0001", in_ready);
        end
        tick();
        tick();
        #1;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b data=%h rdy=%b want 1 deadbeef 0000",
                     out_valid, out_data, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 4'b0000;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0
            || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_stall: valid=%b data=%h sel=%0d rdy=%b want 0 0 0 0000",
                     out_valid, out_data, out_sel, in_ready);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        in_data[2] = 32'h00000022;
        in_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_rdy: got %b want 0100", in_ready);
        end
        tick();
        in_valid = 4'b0000;
        #1;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'h22 || out_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL single_out: valid=%b data=%h sel=%0d want 1 00000022 2",
                     out_valid, out_data, out_sel);
        end
        // ptr should now be 3: channel 3 wins a full contention.
        in_valid = 4'b1111;
        #1;
        n_chk++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_ptr: rdy=%b want 1000", in_ready);
        end
        in_valid = 4'b0000;
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'h22 || out_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL drain_only: valid=%b data=%h sel=%0d want 0 00000022 2",
                     out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_full_contention();
        logic [1:0] exp_sel;
        do_reset();
        set_contention_data();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL cont_first_rdy: got %b want 0001", in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_sel = 2'(c % 4);
            n_chk++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel
                || out_data !== 32'hA0 + 32'(exp_sel)) begin
                n_fail++;
                $display("FAIL contention[%0d]: valid=%b sel=%0d data=%h want 1 %0d %h",
                         c, out_valid, out_sel, out_data, exp_sel, 32'hA0 + 32'(exp_sel));
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_contention_data();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 32'hA0 || out_sel !== 2'd0
                || in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid=%b data=%h sel=%0d rdy=%b want 1 a0 0 0000",
                         c, out_valid, out_data, out_sel, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL release_rdy: got %b want 0010", in_ready);
        end
        tick();
        n_chk++;
        if (out_data !== 32'hA1 || out_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL release_word: data=%h sel=%0d want a1 1", out_data, out_sel);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_skip_idle();
        logic [1:0] exp_g [3];
        exp_g[0] = 2'd3;
        exp_g[1] = 2'd0;
        exp_g[2] = 2'd3;
        do_reset();
        set_contention_data();
        out_ready = 1'b1;
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (in_ready !== (4'b0001 << exp_g[c])) begin
                n_fail++;
                $display("FAIL skip_rdy[%0d]: got %b want grant %0d", c, in_ready, exp_g[c]);
            end
            tick();
            n_chk++;
            if (out_sel !== exp_g[c] || out_data !== 32'hA0 + 32'(exp_g[c])) begin
                n_fail++;
                $display("FAIL skip_out[%0d]: sel=%0d data=%h want %0d", c, out_sel,
                         out_data, exp_g[c]);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fixed_prio();
        do_reset();
        set_contention_data();
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_chk++;
            if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0) begin
                n_fail++;
                $display("FAIL fixed[%0d]: valid=%b sel=%0d data=%h want 1 0 a0",
                         c, out_valid, out_sel, out_data);
            end
        end
        in_valid = 4'b1110;
        #1;
        n_chk++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL fixed_drop_rdy: got %b want 0010", in_ready);
        end
        tick();
        n_chk++;
        if (out_sel !== 2'd1 || out_data !== 32'hA1) begin
            n_fail++;
            $display("FAIL fixed_drop: sel=%0d data=%h want 1 a1", out_sel, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = 32'h0;
        test_reset();
        test_reset_mid_stall();
`ifdef RR_MUX_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_single_source();
        test_full_contention();
        test_backpressure();
        test_skip_idle();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
